// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared parameter defaults and FSM state encoding for the FIFO write arbiter
package fifo_arb_pkg;
  localparam int NREQ_DEF = 4;
  localparam int DW_DEF = 8;
  localparam int MAX_BURST_DEF = 4;
  localparam int CNT_W_DEF = 16;
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first eligible index at or above rr_ptr, wrapping around
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N = NREQ_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] rr_ptr,
  output logic          valid,
  output logic [IW-1:0] index
);
  function automatic logic [IW-1:0] wrap(input logic [IW-1:0] p, input int k);
    return IW'((int'(p) + k) % N);
  endfunction
  // scan offsets from farthest to nearest so the nearest eligible index wins
  always_comb begin
    valid = |eligible;
    index = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (eligible[wrap(rr_ptr, k)]) index = wrap(rr_ptr, k);
    end
  end
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: burst-locked round-robin arbiter driving a FIFO write port
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                     wclk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DW-1:0]       req_data,
  input  logic [NREQ-1:0]          enable,
  input  logic                     fifo_full,
  input  logic                     cnt_clr,
  input  logic [$clog2(NREQ)-1:0]  cnt_sel,
  output logic [NREQ-1:0]          gnt,
  output logic                     signal_write,
  output logic [DW-1:0]            write_data,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy,
  output logic [CNT_W-1:0]         cnt_out
);
  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  arb_state_e state;
  logic [BW-1:0] beats;
  logic [IW-1:0] rr_ptr, pick_idx, win_idx;
  logic [NREQ-1:0] eligible;
  logic pick_valid, hold, fire;
  logic [CNT_W-1:0] cnt [NREQ];
  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .eligible(eligible),
    .rr_ptr(rr_ptr),
    .valid(pick_valid),
    .index(pick_idx)
  );
  assign eligible = req & enable;
  assign hold = state == BURST && eligible[owner] && beats < BW'(MAX_BURST);
  assign win_idx = hold ? owner : pick_idx;
  assign fire = rst && !fifo_full && (hold || pick_valid);
  assign gnt = fire ? NREQ'(1) << win_idx : '0;
  assign signal_write = fire;
  assign write_data = fire ? req_data[win_idx*DW +: DW] : '0;
  assign busy = state == BURST;
  assign cnt_out = cnt[cnt_sel];
  // burst FSM: keep the owner while it stays eligible, otherwise rotate; a full FIFO freezes everything
  always_ff @(posedge wclk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      owner <= '0;
      rr_ptr <= '0;
      beats <= '0;
    end else if (!fifo_full) begin
      if (hold) beats <= beats + 1'b1;
      else if (pick_valid) begin
        state <= BURST;
        owner <= pick_idx;
        beats <= BW'(1);
        rr_ptr <= pick_idx == IW'(NREQ - 1) ? '0 : pick_idx + 1'b1;
      end else state <= IDLE;
    end
  end
  // per-requester saturating word counters; clear wins over a same-cycle grant
  always_ff @(posedge wclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (cnt_clr) cnt[i] <= '0;
        else if (gnt[i] && !(&cnt[i])) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: scoreboard bench for the burst round-robin FIFO write arbiter
module tb_fifo_write_arbiter;
  logic wclk = 1'b0, rst = 1'b0, fifo_full = 1'b0, cnt_clr = 1'b0;
  logic [3:0] req = 4'hF, enable = 4'hF, gnt;
  logic [31:0] req_data = 32'h44332211;
  logic [1:0] cnt_sel = 2'd0, owner;
  logic signal_write, busy;
  logic [7:0] write_data, w;
  logic [15:0] cnt_out;
  typedef struct packed {logic [3:0] g; logic [7:0] d;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  logic [7:0] fq[$];
  int seq[4], rd_next[4];
  int n_chk = 0, n_fail = 0;
  bit sb_on = 1'b1, saw_full = 1'b0;

  fifo_write_arbiter #(.NREQ(4), .DW(8), .MAX_BURST(4), .CNT_W(16)) dut (
    .wclk(wclk), .rst(rst), .req(req), .req_data(req_data), .enable(enable),
    .fifo_full(fifo_full), .cnt_clr(cnt_clr), .cnt_sel(cnt_sel), .gnt(gnt),
    .signal_write(signal_write), .write_data(write_data), .owner(owner),
    .busy(busy), .cnt_out(cnt_out)
  );

  always #10 wclk = ~wclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // one cycle: expected write goes to the scoreboard, expected idle is checked in place
  task automatic cyc(input logic [3:0] eg, input logic [7:0] ed);
    if (eg != 4'd0) exp_q.push_back({eg, ed});
    else begin
      #1;
      chk("no_write", 32'(signal_write), 0);
      chk("no_gnt", 32'(gnt), 0);
    end
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_write", 32'(signal_write), 0);
    chk("rst_data", 32'(write_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner), 0);
    @(posedge wclk);
    #1;
    chk("rst_cnt", 32'(cnt_out), 0);
    rst = 1'b1;
  endtask

  task automatic cnt_chk(input logic [1:0] s, input int exp);
    cnt_sel = s;
    #1;
    chk($sformatf("cnt%0d", s), 32'(cnt_out), exp);
  endtask

  // monitor: every presented write is matched against the oldest expectation
  always @(negedge wclk) begin
    if (sb_on && rst) begin
      chk("onehot", 32'($onehot0(gnt)), 1);
      if (signal_write) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: got gnt=%b data=%h expected no write", gnt, write_data);
        end else begin
          e = exp_q.pop_front();
          chk("sb_gnt", 32'(gnt), 32'(e.g));
          chk("sb_data", 32'(write_data), 32'(e.d));
        end
      end
    end
  end

  initial begin
    do_reset();
    // sole requester: back-to-back bursts with no idle gap
    req = 4'b0001;
    req_data = 32'h00000011;
    for (int c = 0; c < 10; c++) cyc(4'b0001, 8'h11);
    chk("t1_owner", 32'(owner), 0);
    chk("t1_busy", 32'(busy), 1);
    cnt_chk(2'd0, 10);
    cnt_clr = 1'b1;
    cyc(4'b0001, 8'h11);
    cnt_clr = 1'b0;
    cnt_chk(2'd0, 0);
    req = 4'b0000;
    cyc(4'b0000, 8'h00);
    chk("t1_idle", 32'(busy), 0);
    // all four requesting: 4-beat bursts in rotation
    do_reset();
    req = 4'hF;
    req_data = 32'h04030201;
    for (int r = 0; r < 4; r++)
      for (int b = 0; b < 4; b++) cyc(4'(1 << r), 8'(r + 1));
    for (int i = 0; i < 4; i++) cnt_chk(2'(i), 4);
    cyc(4'b0001, 8'h01);
    req = 4'b0000;
    cyc(4'b0000, 8'h00);
    // full stall keeps requester 2's lock
    do_reset();
    req = 4'b0100;
    req_data = 32'h44332211;
    cyc(4'b0100, 8'h33);
    cyc(4'b0100, 8'h33);
    req = 4'hF;
    fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("t3_owner", 32'(owner), 2);
      chk("t3_busy", 32'(busy), 1);
      cyc(4'b0000, 8'h00);
    end
    fifo_full = 1'b0;
    cyc(4'b0100, 8'h33);
    cyc(4'b0100, 8'h33);
    cyc(4'b1000, 8'h44);
    req = 4'b0000;
    cyc(4'b0000, 8'h00);
    // masked requester 2 is skipped
    do_reset();
    enable = 4'b1011;
    req = 4'hF;
    for (int b = 0; b < 4; b++) cyc(4'b0001, 8'h11);
    for (int b = 0; b < 4; b++) cyc(4'b0010, 8'h22);
    for (int b = 0; b < 4; b++) cyc(4'b1000, 8'h44);
    for (int b = 0; b < 4; b++) cyc(4'b0001, 8'h11);
    cnt_chk(2'd2, 0);
    cnt_chk(2'd3, 4);
    req = 4'b0000;
    enable = 4'hF;
    cyc(4'b0000, 8'h00);
    // disabling the owner mid-burst re-arbitrates in the same cycle
    do_reset();
    req = 4'hF;
    cyc(4'b0001, 8'h11);
    cyc(4'b0001, 8'h11);
    enable = 4'b1110;
    cyc(4'b0010, 8'h22);
    chk("t5_owner", 32'(owner), 1);
    req = 4'b0000;
    enable = 4'hF;
    cyc(4'b0000, 8'h00);
    // reset mid-burst discards the burst and restarts at index 0
    do_reset();
    req = 4'hF;
    cyc(4'b0001, 8'h11);
    cyc(4'b0001, 8'h11);
    rst = 1'b0;
    #1;
    chk("t6_gnt", 32'(gnt), 0);
    chk("t6_write", 32'(signal_write), 0);
    chk("t6_busy", 32'(busy), 0);
    @(posedge wclk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) cnt_chk(2'(i), 0);
    cyc(4'b0001, 8'h11);
    req = 4'b0000;
    cyc(4'b0000, 8'h00);
    chk("sb_empty", 32'(exp_q.size()), 0);
    // depth-8 FIFO model: no write while full, per-requester order preserved
    sb_on = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      seq[i] = 0;
      rd_next[i] = 0;
    end
    req = 4'hF;
    for (int c = 0; c < 80; c++) begin
      if (c >= 60) req = 4'b0000;
      fifo_full = fq.size() == 8;
      if (fifo_full) saw_full = 1'b1;
      for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'(i * 64 + seq[i]);
      #1;
      chk("m_onehot", 32'($onehot0(gnt)), 1);
      if (fifo_full) chk("m_stall", 32'(signal_write), 0);
      if (signal_write) begin
        fq.push_back(write_data);
        for (int i = 0; i < 4; i++) if (gnt[i]) seq[i]++;
      end
      if (c % 3 == 0 && fq.size() > 0) begin
        w = fq.pop_front();
        chk("m_order", 32'(w[5:0]), 32'(rd_next[w[7:6]] % 64));
        rd_next[w[7:6]]++;
      end
      @(posedge wclk);
      #1;
    end
    fifo_full = 1'b0;
    while (fq.size() > 0) begin
      w = fq.pop_front();
      chk("m_order", 32'(w[5:0]), 32'(rd_next[w[7:6]] % 64));
      rd_next[w[7:6]]++;
    end
    chk("m_saw_full", 32'(saw_full), 1);
    for (int i = 0; i < 4; i++) begin
      chk("m_lost", 32'(rd_next[i]), 32'(seq[i]));
      chk("m_progress", 32'(seq[i] > 2), 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of write requesters.
REQ-002 SHALL have parameter DW, default 8: data width, equal to the FIFO write_data width.
REQ-003 SHALL have parameter MAX_BURST, default 4: maximum consecutive grants to one owner.
REQ-004 SHALL have parameter CNT_W, default 16: per-requester word counter width.
REQ-005 SHALL have port wclk, input, 1: single clock, which is the FIFO write clock.
REQ-006 SHALL have port rst, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port req, input, NREQ: per-requester write request, held until granted.
REQ-008 SHALL have port req_data, input, NREQ*DW: packed requester data; slice i = [i*DW +: DW].
REQ-009 SHALL have port enable, input, NREQ: per-requester enable mask.
REQ-010 SHALL have port fifo_full, input, 1: FIFO full flag from the wclk domain.
REQ-011 SHALL have port gnt, output, NREQ: one-hot; requester i's word is written on this edge.
REQ-012 SHALL have port signal_write, output, 1: FIFO write strobe.
REQ-013 SHALL have port write_data, output, DW: FIFO write data.
REQ-014 SHALL have port owner, output, clog2(NREQ): current burst owner.
REQ-015 SHALL have port busy, output, 1: high in BURST state.
REQ-016 SHALL have ports cnt_clr, input, 1 and cnt_sel, input, clog2(NREQ): synchronous clear of all counters, and counter read select.
REQ-017 SHALL have port cnt_out, output, CNT_W: word count of requester cnt_sel.

Function
REQ-018 SHALL define eligible[i] = req[i] & enable[i].
REQ-019 SHALL compute gnt, signal_write and write_data combinationally in the current cycle, with zero-cycle grant latency; the word is consumed at the next wclk rising edge.
REQ-020 SHALL drive signal_write = |gnt and write_data = req_data slice of the granted index, and write_data = 0 when there is no grant.
REQ-021 SHALL issue no grant while fifo_full=1; state, owner, beat count and pointer hold, so a burst owner keeps its lock across a stall.
REQ-022 SHALL use a two-state FSM with states IDLE and BURST.
REQ-023 SHALL, in BURST with eligible[owner], beats<MAX_BURST and !fifo_full: grant owner and increment beats.
REQ-024 SHALL otherwise, when !fifo_full and any requester is eligible, grant the first eligible index searching upward, with wrap, from rr_ptr; it then sets owner=winner, beats=1, rr_ptr=winner+1 mod NREQ and enters BURST.
REQ-025 SHALL go to IDLE and leave owner unchanged when !fifo_full and no requester is eligible.
REQ-026 SHALL allow a sole eligible requester whose burst reaches MAX_BURST to be re-granted immediately, starting a new burst with beats=1, with no idle cycle.
REQ-027 SHALL drop owner's lock when enable[owner] is deasserted mid-burst; arbitration happens in the same cycle.
REQ-028 SHALL increment counter[i] on each gnt[i], saturating at all-ones; cnt_clr has priority over the increment.
REQ-029 SHALL guarantee, per requester, at most one grant per cycle; gnt SHALL never have more than one bit set.

Reset
REQ-030 SHALL, while rst=0, asynchronously force state=IDLE, owner=0, rr_ptr=0, beats=0 and all counters=0.
REQ-031 SHALL force gnt=0, signal_write=0, write_data=0 and busy=0 while rst=0, regardless of req.
REQ-032 SHALL, on reset release, allow the first grant on the first edge where eligible and !fifo_full; reset asserted mid-burst discards the burst with no partial write.

Structure
REQ-033 SHALL place NREQ, DW, MAX_BURST and CNT_W defaults and the FSM state encoding in a shared package fifo_arb_pkg.
REQ-034 SHALL implement the wrap-around first-eligible search as one sub-module rr_pick: inputs eligible and rr_ptr, outputs valid and index.
REQ-035 SHALL connect directly to the existing fifo write port: signal_write, write_data, full, wclk, rst.

Verification
REQ-036 SHALL cover: req=0001, data0=8'h11, full=0 -> gnt=0001 for 4 cycles, then 1 cycle with beats reset to 1, then gnt again; owner=0; FIFO reads back 8'h11 in order.
REQ-037 SHALL cover: req=1111 held, data i=i+1 -> grant sequence 0x4, 1x4, 2x4, 3x4, then 0 again; count for each requester=4 after 16 cycles.
REQ-038 SHALL cover: owner=2 at beats=2 with fifo_full asserted for 3 cycles -> gnt=0 and signal_write=0 during full, then 2 further grants to requester 2 before rotation.
REQ-039 SHALL cover: enable=1011 with req=1111 -> requester 2 is never granted and cnt_out for cnt_sel=2 stays 0.
REQ-040 SHALL cover: rst pulled low mid-burst -> gnt=0 immediately; after release, the first grant goes to index 0, and the counters read 0.
REQ-041 SHALL cover: fill a depth-8 FIFO from 4 requesters, with full checked against a behavioral model every wclk -> no write is issued while full, and no data is lost or reordered per requester.
